rr_shared_reg_arbiter: RTL and testbench



---
 rtl/rr_shared_reg_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_shared_reg_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter that shares one W-bit register among N writers.
// Each transaction runs grant, then commit with ack, then back to idle.
module rr_shared_reg_arbiter #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic             abort,
    output logic [W-1:0]     q,
    output logic [IDX_W-1:0] owner,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACK
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_win;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     r_ack;
    logic             r_abort;
    logic [W-1:0]     r_q;
    logic [IDX_W-1:0] r_owner;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_win_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [N-1:0]     w_ack_nxt;
    logic             w_abort_nxt;
    logic [W-1:0]     w_q_nxt;
    logic [IDX_W-1:0] w_owner_nxt;

    logic [W-1:0]     w_slot [N];
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_slot[i] = wdata[i*W +: W];
        end
    end

    // Scan upward from the slot after the last committer, wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_abort_nxt = 1'b0;
        w_q_nxt     = r_q;
        w_owner_nxt = r_owner;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = N'(1) << w_sel;
                    w_win_nxt   = w_sel;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_gnt_nxt = '0;
                if (req[r_win]) begin
                    w_q_nxt     = w_slot[r_win];
                    w_owner_nxt = r_win;
                    w_ptr_nxt   = r_win;
                    w_ack_nxt   = N'(1) << r_win;
                    w_state_nxt = S_ACK;
                end else begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ptr   <= IDX_W'(N - 1);
            r_win   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_abort <= 1'b0;
            r_q     <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_abort <= w_abort_nxt;
            r_q     <= w_q_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign abort = r_abort;
    assign q     = r_q;
    assign owner = r_owner;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Directed bench for the round-robin shared-register arbiter.
// Scenario tasks run in sequence; a per-cycle monitor checks invariants.
module tb_rr_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           abort;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy;

    int tests = 0;
    int fails = 0;

    rr_shared_reg_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .abort(abort), .q(q),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    // busy is high exactly in GRANT (gnt set) and ACK (ack set).
    always @(negedge clk) begin
        if (resetn) begin
            tests++;
            if (!$onehot0(gnt) || !$onehot0(ack) || (gnt & ack) != 0
                || (abort && |ack) || busy !== (|gnt || |ack)) begin
                fails++;
                $display("FAIL invariant: gnt=%b ack=%b abort=%b busy=%b",
                         gnt, ack, abort, busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        resetn = 1'b0;
        cyc(); cyc();
        resetn = 1'b1;
        cyc();
        set_wd(0, 8'hFF);
        req = 4'b0001;
        cyc(); cyc();
        req = 4'b0000;
        tests++;
        if (q !== 8'hFF) begin
            fails++; $display("FAIL pre_reset_q: got %h want ff", q);
        end
        cyc();
        #2 resetn = 1'b0;
        #1;
        tests++;
        if ({q, gnt, ack, abort, owner, busy} !== '0) begin
            fails++;
            $display("FAIL reset_state: q=%h gnt=%b ack=%b abort=%b owner=%0d busy=%b",
                     q, gnt, ack, abort, owner, busy);
        end
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        set_wd(1, 8'hA5);
        req = 4'b0010;
        cyc();
        tests++;
        if (gnt !== 4'b0010 || ack !== 4'b0000 || busy !== 1'b1 || q !== 8'h00) begin
            fails++;
            $display("FAIL single_grant: gnt=%b ack=%b busy=%b q=%h want 0010/0000/1/00",
                     gnt, ack, busy, q);
        end
        cyc();
        req = 4'b0000;
        tests++;
        if (q !== 8'hA5 || ack !== 4'b0010 || gnt !== 4'b0000 || owner !== 2'd1) begin
            fails++;
            $display("FAIL single_commit: q=%h ack=%b gnt=%b owner=%0d want a5/0010/0000/1",
                     q, ack, gnt, owner);
        end
        cyc();
        tests++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin
            fails++;
            $display("FAIL single_idle: busy=%b ack=%b want 0/0000", busy, ack);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_oh;
        resetn = 1'b0;
        #2 resetn = 1'b1;
        for (int i = 0; i < N; i++) set_wd(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_oh = 4'b0001 << (t % N);
            cyc();
            tests++;
            if (gnt !== exp_oh) begin
                fails++; $display("FAIL rr_gnt%0d: got %b want %b", t, gnt, exp_oh);
            end
            cyc();
            tests++;
            if (ack !== exp_oh || q !== 8'(8'h10 + (t % N))) begin
                fails++;
                $display("FAIL rr_ack%0d: ack=%b q=%h want %b/%h",
                         t, ack, q, exp_oh, 8'(8'h10 + (t % N)));
            end
            cyc();
            tests++;
            if (busy !== 1'b0) begin
                fails++; $display("FAIL rr_idle%0d: busy=%b want 0", t, busy);
            end
        end
        req = 4'b0000;
        cyc();
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_oh;
        set_wd(3, 8'h33);
        set_wd(0, 8'hC0);
        for (int t = 0; t < 2; t++) begin
            exp_oh = (t == 0) ? 4'b1000 : 4'b0001;
            req = 4'b1001;
            cyc();
            tests++;
            if (gnt !== exp_oh) begin
                fails++; $display("FAIL wrap_gnt%0d: got %b want %b", t, gnt, exp_oh);
            end
            cyc();
            req = 4'b0000;
            tests++;
            if (ack !== exp_oh || q !== ((t == 0) ? 8'h33 : 8'hC0)) begin
                fails++;
                $display("FAIL wrap_ack%0d: ack=%b q=%h want %b/%h",
                         t, ack, q, exp_oh, (t == 0) ? 8'h33 : 8'hC0);
            end
            cyc();
        end
    endtask

    task automatic test_withdraw();
        set_wd(2, 8'h22);
        req = 4'b0100;
        cyc();
        tests++;
        if (gnt !== 4'b0100) begin
            fails++; $display("FAIL wd_gnt: got %b want 0100", gnt);
        end
        req = 4'b0000;
        cyc();
        tests++;
        if (abort !== 1'b1 || ack !== 4'b0000 || gnt !== 4'b0000
            || q !== 8'hC0 || owner !== 2'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL wd_abort: abort=%b ack=%b gnt=%b q=%h owner=%0d busy=%b",
                     abort, ack, gnt, q, owner, busy);
        end
        req = 4'b0101;
        cyc();
        tests++;
        if (abort !== 1'b0 || gnt !== 4'b0100) begin
            fails++;
            $display("FAIL wd_regrant: abort=%b gnt=%b want 0/0100", abort, gnt);
        end
        cyc();
        req = 4'b0000;
        tests++;
        if (ack !== 4'b0100 || q !== 8'h22 || owner !== 2'd2) begin
            fails++;
            $display("FAIL wd_commit: ack=%b q=%h owner=%0d want 0100/22/2",
                     ack, q, owner);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        set_wd(3, 8'h3C);
        set_wd(1, 8'h3C);
        req = 4'b1010;
        cyc();
        tests++;
        if (gnt !== 4'b1000) begin
            fails++; $display("FAIL mid_gnt: got %b want 1000", gnt);
        end
        #2 resetn = 1'b0;
        #1;
        tests++;
        if (q !== 8'h00 || gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: q=%h gnt=%b ack=%b busy=%b want 00/0000/0000/0",
                     q, gnt, ack, busy);
        end
        #4 resetn = 1'b1;
        cyc();
        tests++;
        if (gnt !== 4'b0010 || ack !== 4'b0000) begin
            fails++;
            $display("FAIL mid_post_gnt: gnt=%b ack=%b want 0010/0000", gnt, ack);
        end
        cyc();
        req = 4'b0000;
        tests++;
        if (ack !== 4'b0010 || q !== 8'h3C || owner !== 2'd1) begin
            fails++;
            $display("FAIL mid_post_ack: ack=%b q=%h owner=%0d want 0010/3c/1",
                     ack, q, owner);
        end
        cyc();
        tests++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_final: ack=%b busy=%b want 0000/0", ack, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
